pool_fc_flatten_bridge: RTL and testbench
=========================================

// Module: pool_fc_flatten_bridge
// PURPOSE
//  Inter-layer stage between pool_layer and fc_layer. Takes one pooled pixel per handshake, all channels
//  in parallel. Serialises the channels into the fc_layer input buffer, one word per cycle, at flattened
//  addresses. Pulses the fc start once the whole feature map is written. Back-pressures the pool stage.
// PARAMETERS
//  datatype_size  4   width of one activation word
//  channels       10  pool channels (= pool input_channels)
//  img_width      22  pool input image width
//  kernel_dim     2   pool window size
//  out_width      img_width/kernel_dim (11); derived, do not override
//  out_pixels     out_width**2 (121); derived
//  fc_input_size  channels*out_pixels (1210); derived, equals downstream fc input_size
// PORTS
//  clk             in   1                       clock
//  rst             in   1                       reset, synchronous, active-high
//  i_valid         in   1                       pool presents one pooled pixel on i_data
//  i_data          in   [datatype_size-1:0] x [channels-1:0]   per-channel pooled values
//  o_busy          out  1                       to pool i_next_busy; i_valid is illegal while high
//  i_fc_busy       in   1                       fc_layer o_busy
//  o_ibuf_we       out  1                       fc ibuf write enable
//  o_ibuf_wr_data  out  datatype_size           fc ibuf write data
//  o_ibuf_addr     out  $clog2(fc_input_size)   fc ibuf write address
//  o_start         out  1                       one-cycle pulse to fc i_start
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst is synchronous, active-high.
//  Reset: state=IDLE; pos_cnt=0; ch_cnt=0; capture register cleared.
//   o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr and o_start are all 0. Counter widths use max(1,$clog2(n)).
//  States:
//   IDLE: i_valid && !o_busy -> capture i_data, ch_cnt=0 -> SHIFT.
//   SHIFT: one registered write per cycle: data=cap[ch_cnt], addr=ch_cnt*out_pixels+pos_cnt.
//    ch_cnt increments each cycle.
//    On ch_cnt==channels-1: if pos_cnt==out_pixels-1, pos_cnt=0 and go to START.
//    Otherwise pos_cnt++ and go to IDLE.
//   START: o_start=1 for exactly one cycle when i_fc_busy==0, then IDLE. Held while i_fc_busy==1.
//  o_busy (combinational) = (state!=IDLE) || (pos_cnt==0 && i_fc_busy).
//   Frame gate: no new frame is written while fc is still consuming its buffer.
//  Latency: i_valid captured at edge t; writes visible t+1..t+channels; o_busy high t+1..t+channels.
//   The last pixel's o_start asserts at earliest cycle t+channels+1.
//  i_valid while o_busy=1: ignored, no capture. This is a protocol error, flagged by the bench assertion.
//  Within a frame every address 0..fc_input_size-1 is written exactly once. No address wrap inside a frame.
//   Addresses restart at 0 on the next frame.
//  Reset mid-frame: partial frame discarded, no o_start. The next accepted pixel is pos 0.
//  o_ibuf_we is low in every cycle that is not a SHIFT write.
// CONFIGURATION
//  FLATTEN_HWC_EN defined: pixel-major order, addr = pos_cnt*channels + ch_cnt.
//  Not defined: channel-major order (CHW), addr = ch_cnt*out_pixels + pos_cnt.
//  Timing, handshake and start behaviour are identical in both modes.
// STRUCTURE
//  cim_pkg: bridge state enum (IDLE, SHIFT, START); helper function clog2_min1(n).
//  Sub-module flatten_addr_gen: holds pos_cnt/ch_cnt, emits addr, last_ch, last_pix; the macro select lives
//   here. The FSM and capture register stay in the top module.
// TESTING
//  1 Single pixel: i_valid at pos 0, i_data[c]=c -> 10 writes, addr 0,121,242,...,1089, data 0..9.
//    o_busy high 10 cycles. No o_start.
//  2 Full frame: 121 pixels, random data -> 1210 writes, each addr exactly once with matching data.
//    o_start single 1-cycle pulse the cycle after the last write.
//  3 End-of-frame stall: i_fc_busy=1 from the last write -> o_start withheld and o_busy=1.
//    Release i_fc_busy -> o_start in the next cycle, then IDLE.
//  4 Frame gate: IDLE, pos 0, i_fc_busy=1 -> o_busy=1 and i_valid ignored. Release -> next i_valid accepted.
//  5 Reset at pos 50 mid-SHIFT -> next cycle all outputs 0. Following pixel writes addr 0.
//  6 FLATTEN_HWC_EN: pixel at pos 1, channel 3 -> addr 13. Full frame covers 0..1209 exactly once.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared definitions for the pool -> fc flatten bridge.
//   bridge_state_t : bridge FSM states (IDLE, SHIFT, START)
//   clog2_min1(n)  : counter width helper, never returns less than 1 bit
package cim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_START = 2'd2
    } bridge_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flatten_addr_gen.sv
// Channel / pixel position counters and fc input-buffer address for the flatten bridge.
// Build option: FLATTEN_HWC_EN selects pixel-major (HWC) order, addr = pos*channels + ch.
//   Default is channel-major (CHW) order, addr = ch*out_pixels + pos.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_clear_ch    pixel accepted: restart the channel counter
//   i_step        one channel written this cycle
//   o_ch          current channel index
//   o_addr        flattened address of the current (ch, pos)
//   o_last_ch     current channel is the last one of the pixel
//   o_last_pix    current pixel is the last one of the frame
//   o_pos_zero    next pixel to be accepted starts a new frame
module flatten_addr_gen
    import cim_pkg::*;
#(
    parameter int channels   = 10,
    parameter int out_pixels = 121,
    localparam int CH_W      = clog2_min1(channels),
    localparam int POS_W     = clog2_min1(out_pixels),
    localparam int ADDR_W    = clog2_min1(channels * out_pixels)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear_ch,
    input  logic              i_step,
    output logic [CH_W-1:0]   o_ch,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_ch,
    output logic              o_last_pix,
    output logic              o_pos_zero
);

    logic [CH_W-1:0]  r_ch;
    logic [POS_W-1:0] r_pos;

    assign o_ch       = r_ch;
    assign o_last_ch  = (r_ch == CH_W'(channels - 1));
    assign o_last_pix = (r_pos == POS_W'(out_pixels - 1));
    assign o_pos_zero = (r_pos == '0);

`ifdef FLATTEN_HWC_EN
    assign o_addr = ADDR_W'(r_pos) * ADDR_W'(channels) + ADDR_W'(r_ch);
`else
    assign o_addr = ADDR_W'(r_ch) * ADDR_W'(out_pixels) + ADDR_W'(r_pos);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch  <= '0;
            r_pos <= '0;
        end else if (i_clear_ch) begin
            r_ch <= '0;
        end else if (i_step) begin
            if (o_last_ch) begin
                r_ch  <= '0;
                r_pos <= o_last_pix ? '0 : r_pos + 1'b1;
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_fc_flatten_bridge.sv
// Bridge between pool_layer and fc_layer: captures one pooled pixel (all channels),
// writes its channels one per cycle into the fc input buffer at flattened addresses,
// and pulses o_start once the whole feature map has been written.
// Build option: FLATTEN_HWC_EN (handled in flatten_addr_gen) selects HWC address order.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_valid/i_data  pooled pixel from pool_layer (illegal while o_busy)
//   o_busy          back-pressure to pool_layer
//   i_fc_busy       fc_layer still consuming its buffer
//   o_ibuf_we/o_ibuf_wr_data/o_ibuf_addr   registered fc ibuf write port
//   o_start         one-cycle fc start pulse
//
// state  | meaning
// IDLE   | waiting for a pooled pixel
// SHIFT  | writing captured channels, one per cycle
// START  | frame complete, waiting for fc to be free to pulse start
module pool_fc_flatten_bridge
    import cim_pkg::*;
#(
    parameter int datatype_size  = 4,
    parameter int channels       = 10,
    parameter int img_width      = 22,
    parameter int kernel_dim     = 2,
    localparam int out_width     = img_width / kernel_dim,
    localparam int out_pixels    = out_width * out_width,
    localparam int fc_input_size = channels * out_pixels,
    localparam int CH_W          = clog2_min1(channels),
    localparam int ADDR_W        = clog2_min1(fc_input_size)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_valid,
    input  logic [channels-1:0][datatype_size-1:0]  i_data,
    output logic                                    o_busy,
    input  logic                                    i_fc_busy,
    output logic                                    o_ibuf_we,
    output logic [datatype_size-1:0]                o_ibuf_wr_data,
    output logic [ADDR_W-1:0]                       o_ibuf_addr,
    output logic                                    o_start
);

    bridge_state_t r_state;
    bridge_state_t w_state_nxt;

    logic [channels-1:0][datatype_size-1:0] r_cap;
    logic [CH_W-1:0]   w_ch;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last_ch;
    logic              w_last_pix;
    logic              w_pos_zero;
    logic              w_accept;
    logic              w_shift;

    // A new frame may not begin while fc still reads the previous buffer.
    assign o_busy   = (r_state != ST_IDLE) || (w_pos_zero && i_fc_busy);
    assign w_accept = (r_state == ST_IDLE) && i_valid && !o_busy;
    assign w_shift  = (r_state == ST_SHIFT);

    flatten_addr_gen #(
        .channels   (channels),
        .out_pixels (out_pixels)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clear_ch (w_accept),
        .i_step     (w_shift),
        .o_ch       (w_ch),
        .o_addr     (w_addr),
        .o_last_ch  (w_last_ch),
        .o_last_pix (w_last_pix),
        .o_pos_zero (w_pos_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_ch) w_state_nxt = w_last_pix ? ST_START : ST_IDLE;
            end
            ST_START: begin
                if (!i_fc_busy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap <= '0;
        end else if (w_accept) begin
            r_cap <= i_data;
        end
    end

    // Write port and start are registered so fc sees clean, glitch-free strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ibuf_we      <= 1'b0;
            o_ibuf_wr_data <= '0;
            o_ibuf_addr    <= '0;
            o_start        <= 1'b0;
        end else begin
            o_ibuf_we <= w_shift;
            o_start   <= (r_state == ST_START) && !i_fc_busy;
            if (w_shift) begin
                o_ibuf_wr_data <= r_cap[w_ch];
                o_ibuf_addr    <= w_addr;
            end
        end
    end

endmodule

// File: tb/tb_pool_fc_flatten_bridge.sv
module tb_pool_fc_flatten_bridge;

    localparam int DW = 4;
    localparam int CH = 10;
    localparam int OP = 121;
    localparam int FC = CH * OP;
    localparam int AW = 11;

    typedef struct packed {
        logic          is_start;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   i_valid = 1'b0;
    logic [CH-1:0][DW-1:0]  i_data = '0;
    logic                   o_busy;
    logic                   i_fc_busy = 1'b0;
    logic                   o_ibuf_we;
    logic [DW-1:0]          o_ibuf_wr_data;
    logic [AW-1:0]          o_ibuf_addr;
    logic                   o_start;

    pool_fc_flatten_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_busy         (o_busy),
        .i_fc_busy      (i_fc_busy),
        .o_ibuf_we      (o_ibuf_we),
        .o_ibuf_wr_data (o_ibuf_wr_data),
        .o_ibuf_addr    (o_ibuf_addr),
        .o_start        (o_start)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    bit   seen[FC];
    int   seen_cnt = 0;
    int   start_cnt = 0;
    int   proto_cnt = 0;
    logic prev_start = 1'b0;
    int   pos_m = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_addr(input int p, input int c);
`ifdef FLATTEN_HWC_EN
        return p * CH + c;
`else
        return c * OP + p;
`endif
    endfunction

    task automatic clear_seen();
        for (int a = 0; a < FC; a++) seen[a] = 1'b0;
        seen_cnt = 0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (i_valid && o_busy) proto_cnt++;
            if (o_ibuf_we) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write: got addr %0d, expected no write", o_ibuf_addr);
                end else begin
                    e = q.pop_front();
                    check("write_not_start", 0, int'(e.is_start));
                    check("wr_addr", int'(o_ibuf_addr), int'(e.addr));
                    check("wr_data", int'(o_ibuf_wr_data), int'(e.data));
                    check("addr_in_range", int'(o_ibuf_addr < AW'(FC)), 1);
                    if (o_ibuf_addr < AW'(FC)) begin
                        check("addr_once", int'(seen[o_ibuf_addr]), 0);
                        seen[o_ibuf_addr] = 1'b1;
                        seen_cnt++;
                    end
                end
            end
            if (o_start) begin
                start_cnt++;
                check("start_width", int'(prev_start), 0);
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_start: got start, expected nothing pending");
                end else begin
                    e = q.pop_front();
                    check("start_expected", int'(e.is_start), 1);
                end
                check("frame_coverage", seen_cnt, FC);
                clear_seen();
            end
            prev_start = o_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [CH-1:0][DW-1:0] d);
        exp_t e;
        int   k;
        k = 0;
        while (o_busy && k < 100) begin
            tick();
            k++;
        end
        if (o_busy) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: got o_busy=1, expected 0 within 100 cycles");
        end
        for (int c = 0; c < CH; c++) begin
            e.is_start = 1'b0;
            e.addr     = AW'(ref_addr(pos_m, c));
            e.data     = d[c];
            q.push_back(e);
        end
        if (pos_m == OP - 1) begin
            e.is_start = 1'b1;
            e.addr     = '0;
            e.data     = '0;
            q.push_back(e);
            pos_m = 0;
        end else begin
            pos_m++;
        end
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    function automatic logic [CH-1:0][DW-1:0] rand_pix();
        logic [CH-1:0][DW-1:0] d;
        for (int c = 0; c < CH; c++) d[c] = DW'($urandom_range(0, (1 << DW) - 1));
        return d;
    endfunction

    // Random pixels with random gaps; fc busy toggles randomly only mid-frame.
    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            i_fc_busy = (pos_m != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_pixel(rand_pix());
        end
        i_fc_busy = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && q.size() > 0; i++) tick();
        check("drain_queue", q.size(), 0);
    endtask

    initial begin
        logic [CH-1:0][DW-1:0] d;
        int cnt;
        int starts0;
        int proto0;

        clear_seen();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_we", int'(o_ibuf_we), 0);
        check("reset_data", int'(o_ibuf_wr_data), 0);
        check("reset_addr", int'(o_ibuf_addr), 0);
        check("reset_start", int'(o_start), 0);
        check("reset_busy", int'(o_busy), 0);

        // single pixel, data = channel index
        for (int c = 0; c < CH; c++) d[c] = DW'(c);
        send_pixel(d);
        cnt = 0;
        for (int i = 0; i < 30 && o_busy; i++) begin
            cnt++;
            tick();
        end
        check("single_busy_cycles", cnt, CH);
        wait_drain();
        check("single_no_start", start_cnt, 0);

        // complete frame 1, check start timing after last write
        send_random(OP - 2);
        i_fc_busy = 1'b0;
        send_pixel(rand_pix());
        repeat (10) tick();
        check("last_write_we", int'(o_ibuf_we), 1);
        check("last_write_addr", int'(o_ibuf_addr), ref_addr(OP - 1, CH - 1));
        check("start_not_with_write", int'(o_start), 0);
        tick();
        check("start_after_last", int'(o_start), 1);
        check("we_low_at_start", int'(o_ibuf_we), 0);
        tick();
        check("start_one_cycle", int'(o_start), 0);
        wait_drain();
        check("frame1_starts", start_cnt, 1);

        // frame 2 with end-of-frame stall
        send_random(OP - 1);
        send_pixel(rand_pix());
        repeat (10) tick();
        i_fc_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_start", int'(o_start), 0);
            check("stall_busy", int'(o_busy), 1);
        end
        i_fc_busy = 1'b0;
        tick();
        check("stall_release_start", int'(o_start), 1);
        tick();
        check("stall_after_start", int'(o_start), 0);
        check("stall_idle_busy", int'(o_busy), 0);
        wait_drain();
        check("frame2_starts", start_cnt, 2);

        // frame gate: pos 0, fc busy, i_valid must be ignored
        proto0 = proto_cnt;
        i_fc_busy = 1'b1;
        #1;
        check("gate_busy", int'(o_busy), 1);
        i_valid = 1'b1;
        i_data  = rand_pix();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gate_busy_held", int'(o_busy), 1);
            check("gate_no_write", int'(o_ibuf_we), 0);
        end
        i_valid = 1'b0;
        check("gate_ignored_cycles", proto_cnt - proto0, 3);
        i_fc_busy = 1'b0;
        send_pixel(rand_pix());

        // reset while writing pixel at pos 50
        send_random(49);
        send_pixel(rand_pix());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        clear_seen();
        pos_m = 0;
        check("rst_mid_we", int'(o_ibuf_we), 0);
        check("rst_mid_data", int'(o_ibuf_wr_data), 0);
        check("rst_mid_addr", int'(o_ibuf_addr), 0);
        check("rst_mid_start", int'(o_start), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        starts0 = start_cnt;

        // frame 3 starts fresh at pos 0
        send_pixel(rand_pix());
        send_random(OP - 1);
        wait_drain();
        check("frame3_starts", start_cnt - starts0, 1);
        check("total_starts", start_cnt, 3);
        check("no_protocol_misuse", proto_cnt - proto0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
